// File: rtl/mycpu_pkg.sv
// -----------------------------------------------------------------------------
// mycpu_pkg
// Shared types for the CPU I/O space: the register map of the I/O responder,
// the timer state encoding and the bit positions inside TMR_CTRL.
// Ports: none (package).
// -----------------------------------------------------------------------------
package mycpu_pkg;

  // Word offsets inside the 8-word I/O window (offsets 6 and 7 are unused)
  typedef enum logic [2:0] {
    IO_GPIO_OUT  = 3'd0,
    IO_GPIO_IN   = 3'd1,
    IO_TMR_LOAD  = 3'd2,
    IO_TMR_COUNT = 3'd3,
    IO_TMR_CTRL  = 3'd4,
    IO_STATUS    = 3'd5
  } io_reg_t;

  // Timer control states
  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_DONE = 2'd2
  } tmr_state_t;

  // Bit positions inside TMR_CTRL
  localparam int TMR_RUN_BIT = 0;
  localparam int TMR_AR_BIT  = 1;

  // True when an access lands inside the 8-word window starting at base
  function automatic logic io_hit(input logic iom, input logic [15:0] addr,
                                  input logic [15:0] base);
    return iom && (addr[15:3] == base[15:3]);
  endfunction

endpackage

// File: rtl/io_responder_timer.sv
// -----------------------------------------------------------------------------
// io_timer
// Down-counting timer for the I/O responder: prescaler, control FSM, COUNT,
// CTRL and the sticky expired flag. Only built when IO_TIMER_EN is defined;
// without it the responder has no timer and this module does not exist.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_load_we       write strobe for TMR_LOAD
//   i_ctrl_we       write strobe for TMR_CTRL
//   i_status_we     write strobe for STATUS (write-1-to-clear)
//   i_wdata[15:0]   CPU write data
//   o_load[15:0]    TMR_LOAD value
//   o_count[15:0]   TMR_COUNT value
//   o_ctrl[1:0]     TMR_CTRL value ([0]=run, [1]=auto-reload)
//   o_expired       sticky expiry flag (also the interrupt level)
// -----------------------------------------------------------------------------
`ifdef IO_TIMER_EN
module io_timer
  import mycpu_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load_we,
  input  logic        i_ctrl_we,
  input  logic        i_status_we,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_load,
  output logic [15:0] o_count,
  output logic [1:0]  o_ctrl,
  output logic        o_expired
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_presc;
  logic [15:0]   r_load;
  logic [15:0]   r_count;
  logic [1:0]    r_ctrl;
  logic          r_expired;
  tmr_state_t    r_state;

  logic          w_tick;
  tmr_state_t    w_stateNext;
  logic [15:0]   w_countNext;
  logic [1:0]    w_ctrlNext;
  logic          w_expSet;

  assign w_tick = (r_presc == PW'(PRESCALE - 1));

  // Free-running prescaler; restarting the timer via CTRL realigns it so the
  // first decrement is a full PRESCALE period after the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (i_ctrl_we || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Next-state logic. A CTRL write overrides anything the counter would do
  // that edge. A start with LOAD==0 expires immediately. COUNT<=1 is treated
  // as the terminal value so the counter can never wrap below zero, even if
  // a zero LOAD was reloaded.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_ctrlNext  = r_ctrl;
    w_expSet    = 1'b0;
    if (i_ctrl_we) begin
      w_ctrlNext = i_wdata[1:0];
      if (i_wdata[TMR_RUN_BIT]) begin
        w_countNext = r_load;
        if (r_load == 16'd0) begin
          w_stateNext = T_DONE;
          w_expSet    = 1'b1;
        end else begin
          w_stateNext = T_RUN;
        end
      end else begin
        w_stateNext = T_IDLE;
      end
    end else if (r_state == T_RUN && w_tick) begin
      if (r_count > 16'd1) begin
        w_countNext = r_count - 16'd1;
      end else begin
        w_expSet = 1'b1;
        if (r_ctrl[TMR_AR_BIT]) begin
          w_countNext = r_load;
        end else begin
          w_countNext             = 16'd0;
          w_stateNext             = T_DONE;
          w_ctrlNext[TMR_RUN_BIT] = 1'b0;
        end
      end
    end
  end

  // State and datapath registers. Expiry beats a simultaneous W1C so an
  // expiry on the clearing edge is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= T_IDLE;
      r_load    <= '0;
      r_count   <= '0;
      r_ctrl    <= '0;
      r_expired <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
      r_ctrl  <= w_ctrlNext;
      if (i_load_we) begin
        r_load <= i_wdata;
      end
      if (w_expSet) begin
        r_expired <= 1'b1;
      end else if (i_status_we && i_wdata[0]) begin
        r_expired <= 1'b0;
      end
    end
  end

  assign o_load    = r_load;
  assign o_count   = r_count;
  assign o_ctrl    = r_ctrl;
  assign o_expired = r_expired;

endmodule
`endif

// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder
// Memory-mapped I/O target answering CPU accesses with iom=1. Holds the GPIO
// output register, a synchroniser on the GPIO inputs, the read mux and, when
// the IO_TIMER_EN macro is defined, a down-counting timer with interrupt.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   iom_in            access targets I/O space
//   wen_in            1 = write, 0 = read
//   addr_in[15:0]     CPU address
//   data_in[15:0]     CPU write data
//   data_out[15:0]    read data (combinational), 0 when not a read hit
//   gpio_in[15:0]     asynchronous external inputs
//   gpio_out[15:0]    registered external outputs
//   tmr_irq_out       timer interrupt level (0 without IO_TIMER_EN)
// -----------------------------------------------------------------------------
module io_responder
  import mycpu_pkg::*;
#(
  parameter logic [15:0] IO_BASE     = 16'hFF00,
  parameter int          PRESCALE    = 1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iom_in,
  input  logic        wen_in,
  input  logic [15:0] addr_in,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic        tmr_irq_out
);

  logic        w_hit;
  logic        w_we;
  logic        w_re;
  io_reg_t     w_off;
  logic [15:0] r_gpioOut;
  logic [15:0] r_sync [SYNC_STAGES];
  logic [15:0] w_rdata;

  assign w_hit = io_hit(iom_in, addr_in, IO_BASE);
  assign w_we  = w_hit && wen_in;
  assign w_re  = w_hit && !wen_in;
  assign w_off = io_reg_t'(addr_in[2:0]);

  // GPIO output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpioOut <= '0;
    end else if (w_we && w_off == IO_GPIO_OUT) begin
      r_gpioOut <= data_in;
    end
  end

  // Synchroniser chain for the asynchronous GPIO inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign gpio_out = r_gpioOut;

`ifdef IO_TIMER_EN
  logic [15:0] w_load;
  logic [15:0] w_count;
  logic [1:0]  w_ctrl;
  logic        w_expired;

  io_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_load_we   (w_we && w_off == IO_TMR_LOAD),
    .i_ctrl_we   (w_we && w_off == IO_TMR_CTRL),
    .i_status_we (w_we && w_off == IO_STATUS),
    .i_wdata     (data_in),
    .o_load      (w_load),
    .o_count     (w_count),
    .o_ctrl      (w_ctrl),
    .o_expired   (w_expired)
  );

  assign tmr_irq_out = w_expired;

  // Read mux, timer build
  always_comb begin
    w_rdata = 16'h0000;
    if (w_re) begin
      case (w_off)
        IO_GPIO_OUT:  w_rdata = r_gpioOut;
        IO_GPIO_IN:   w_rdata = r_sync[SYNC_STAGES-1];
        IO_TMR_LOAD:  w_rdata = w_load;
        IO_TMR_COUNT: w_rdata = w_count;
        IO_TMR_CTRL:  w_rdata = {14'd0, w_ctrl};
        IO_STATUS:    w_rdata = {15'd0, w_expired};
        default:      w_rdata = 16'h0000;
      endcase
    end
  end
`else
  assign tmr_irq_out = 1'b0;

  // Read mux, GPIO-only build: timer offsets read as zero
  always_comb begin
    w_rdata = 16'h0000;
    if (w_re) begin
      case (w_off)
        IO_GPIO_OUT: w_rdata = r_gpioOut;
        IO_GPIO_IN:  w_rdata = r_sync[SYNC_STAGES-1];
        default:     w_rdata = 16'h0000;
      endcase
    end
  end
`endif

  assign data_out = w_rdata;

endmodule

// File: tb/tb_io_responder.sv
// -----------------------------------------------------------------------------
// tb_io_responder
// Self-checking bench for io_responder: directed scenarios followed by random
// bus traffic, all compared against a behavioural model of the register map.
// Timer scenarios are exercised when IO_TIMER_EN is defined; otherwise the
// bench checks that the timer offsets read zero and the interrupt stays low.
// -----------------------------------------------------------------------------
module tb_io_responder;

  localparam logic [15:0] IO_BASE     = 16'hFF00;
  localparam int          PRESCALE    = 1;
  localparam int          SYNC_STAGES = 2;
`ifdef IO_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iom_in = 1'b0;
  logic        wen_in = 1'b0;
  logic [15:0] addr_in = 16'h0000;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] gpio_in = 16'h0000;
  logic [15:0] data_out;
  logic [15:0] gpio_out;
  logic        tmr_irq_out;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [15:0] mGpioOut;
  logic [15:0] mLoad;
  logic [15:0] mCount;
  bit          mRun;
  bit          mAr;
  bit          mExpired;
  bit          mCounting;
  int          mPresc;
  logic [15:0] mHist[$];
  logic [15:0] curGin = 16'h0000;

  io_responder #(
    .IO_BASE     (IO_BASE),
    .PRESCALE    (PRESCALE),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .iom_in      (iom_in),
    .wen_in      (wen_in),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .data_out    (data_out),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .tmr_irq_out (tmr_irq_out)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic bit modelHit(input logic iom, input logic [15:0] addr);
    return iom && (addr[15:3] == IO_BASE[15:3]);
  endfunction

  // Value a read should return given the model state before the edge
  function automatic logic [15:0] modelRead(input logic iom, input logic wen,
                                            input logic [15:0] addr);
    if (!modelHit(iom, addr) || wen) return 16'h0000;
    case (addr[2:0])
      3'd0: return mGpioOut;
      3'd1: return mHist[SYNC_STAGES-1];
      3'd2: return TIMER_ON ? mLoad : 16'h0000;
      3'd3: return TIMER_ON ? mCount : 16'h0000;
      3'd4: return TIMER_ON ? {14'd0, mAr, mRun} : 16'h0000;
      3'd5: return TIMER_ON ? {15'd0, mExpired} : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic modelReset();
    mGpioOut  = 16'h0000;
    mLoad     = 16'h0000;
    mCount    = 16'h0000;
    mRun      = 1'b0;
    mAr       = 1'b0;
    mExpired  = 1'b0;
    mCounting = 1'b0;
    mPresc    = 0;
    mHist     = {};
    for (int i = 0; i < SYNC_STAGES; i++) mHist.push_back(16'h0000);
  endtask

  // Advance the model by one clock edge with the given bus inputs
  task automatic modelEdge(input logic iom, input logic wen,
                           input logic [15:0] addr, input logic [15:0] data,
                           input logic [15:0] gin);
    bit          hitW;
    bit          tick;
    bit          setE;
    logic [2:0]  off;
    logic [15:0] oldLoad;
    hitW    = modelHit(iom, addr) && wen;
    off     = addr[2:0];
    oldLoad = mLoad;
    setE    = 1'b0;
    tick    = (mPresc == PRESCALE - 1);
    mPresc  = tick ? 0 : mPresc + 1;
    if (hitW && off == 3'd4) begin
      mPresc = 0;
      mRun   = data[0];
      mAr    = data[1];
      if (data[0]) begin
        mCount = oldLoad;
        if (oldLoad == 16'd0) begin
          mCounting = 1'b0;
          setE      = 1'b1;
        end else begin
          mCounting = 1'b1;
        end
      end else begin
        mCounting = 1'b0;
      end
    end else if (mCounting && tick) begin
      if (mCount > 16'd1) begin
        mCount = mCount - 16'd1;
      end else begin
        setE = 1'b1;
        if (mAr) begin
          mCount = oldLoad;
        end else begin
          mCount    = 16'd0;
          mCounting = 1'b0;
          mRun      = 1'b0;
        end
      end
    end
    if (hitW && off == 3'd5 && data[0]) mExpired = 1'b0;
    if (setE) mExpired = 1'b1;
    if (hitW && off == 3'd0) mGpioOut = data;
    if (hitW && off == 3'd2) mLoad = data;
    mHist.push_front(gin);
    void'(mHist.pop_back());
  endtask

  // One bus cycle: drive at the falling edge, check read data before the
  // rising edge, check registered outputs just after it
  task automatic applyStimulus(input logic iom, input logic wen,
                               input logic [15:0] addr, input logic [15:0] data,
                               output logic [15:0] obs);
    iom_in  = iom;
    wen_in  = wen;
    addr_in = addr;
    data_in = data;
    gpio_in = curGin;
    #1;
    obs = data_out;
    checkOutput($sformatf("data_out@%h", addr), data_out, modelRead(iom, wen, addr));
    @(posedge clk);
    modelEdge(iom, wen, addr, data, curGin);
    #1;
    checkOutput("gpio_out", gpio_out, mGpioOut);
    checkOutput("irq", {15'd0, tmr_irq_out}, {15'd0, TIMER_ON & mExpired});
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    logic [15:0] obs;
    applyStimulus(1'b1, 1'b1, addr, data, obs);
  endtask

  task automatic rd(input logic [15:0] addr, output logic [15:0] obs);
    applyStimulus(1'b1, 1'b0, addr, 16'h0000, obs);
  endtask

  task automatic doReset();
    rst     = 1'b1;
    iom_in  = 1'b0;
    wen_in  = 1'b0;
    gpio_in = curGin;
    @(posedge clk);
    modelReset();
    #1;
    checkOutput("rst_gpio", gpio_out, 16'h0000);
    checkOutput("rst_irq", {15'd0, tmr_irq_out}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] obs;
    logic [15:0] obsA;
    logic [15:0] obsC;
    logic [2:0]  off;
    logic        iom;
    logic        wen;
    logic [15:0] addr;
    logic [15:0] data;

    modelReset();
    @(negedge clk);
    doReset();
    rd(16'hFF03, obs);
    checkOutput("rst_rd", obs, 16'h0000);

    // GPIO write and readback
    wr(16'hFF00, 16'hA5C3);
    checkOutput("t1_gpio", gpio_out, 16'hA5C3);
    rd(16'hFF00, obs);
    checkOutput("t1_rd", obs, 16'hA5C3);

    // Misses: iom low, address outside window
    applyStimulus(1'b0, 1'b1, 16'hFF00, 16'h1111, obs);
    checkOutput("t2_iom0", gpio_out, 16'hA5C3);
    wr(16'hFE00, 16'h2222);
    checkOutput("t2_addr", gpio_out, 16'hA5C3);
    applyStimulus(1'b0, 1'b0, 16'hFF00, 16'h0000, obs);
    checkOutput("t2_rd_iom0", obs, 16'h0000);
    rd(16'hFE00, obs);
    checkOutput("t2_rd_miss", obs, 16'h0000);

    // Synchroniser latency
    curGin = 16'h1234;
    rd(16'hFF01, obsA);
    rd(16'hFF01, obs);
    rd(16'hFF01, obsC);
    checkOutput("t3_old", obsA, 16'h0000);
    checkOutput("t3_old2", obs, 16'h0000);
    checkOutput("t3_new", obsC, 16'h1234);

`ifdef IO_TIMER_EN
    // One-shot countdown from 3
    wr(16'hFF02, 16'd3);
    wr(16'hFF04, 16'd1);
    rd(16'hFF03, obs);
    checkOutput("t4_c3", obs, 16'd3);
    rd(16'hFF03, obs);
    checkOutput("t4_c2", obs, 16'd2);
    rd(16'hFF03, obs);
    checkOutput("t4_c1", obs, 16'd1);
    checkOutput("t4_irq", {15'd0, tmr_irq_out}, 16'd1);
    rd(16'hFF03, obs);
    checkOutput("t4_c0", obs, 16'd0);
    rd(16'hFF04, obs);
    checkOutput("t4_ctrl", obs, 16'd0);

    // Auto-reload, W1C colliding with expiry
    wr(16'hFF05, 16'd1);
    checkOutput("t5_clr", {15'd0, tmr_irq_out}, 16'd0);
    wr(16'hFF02, 16'd2);
    wr(16'hFF04, 16'd3);
    rd(16'hFF03, obs);
    checkOutput("t5_c2", obs, 16'd2);
    wr(16'hFF05, 16'd1);
    checkOutput("t5_w1c_race", {15'd0, tmr_irq_out}, 16'd1);
    rd(16'hFF03, obs);
    checkOutput("t5_reload", obs, 16'd2);

    // Reset while counting
    wr(16'hFF02, 16'd5);
    wr(16'hFF04, 16'd1);
    doReset();
    rd(16'hFF03, obs);
    checkOutput("t6_count", obs, 16'd0);
    checkOutput("t6_gpio", gpio_out, 16'h0000);
`else
    // Timer offsets absent
    for (int a = 2; a <= 5; a++) begin
      wr(IO_BASE | 16'(a), 16'hFFFF);
      rd(IO_BASE | 16'(a), obs);
      checkOutput($sformatf("notmr_rd%0d", a), obs, 16'h0000);
    end
    wr(16'hFF04, 16'd1);
    wr(16'hFF04, 16'd1);
    checkOutput("notmr_irq", {15'd0, tmr_irq_out}, 16'd0);
`endif

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(99) == 0) begin
        doReset();
      end else begin
        if ($urandom_range(3) == 0) curGin = 16'($urandom);
        iom = ($urandom_range(7) != 0);
        off = 3'($urandom_range(7));
        addr = ($urandom_range(7) == 0) ? 16'($urandom) : {IO_BASE[15:3], off};
        wen = ($urandom_range(2) == 0);
        data = 16'($urandom);
        if (addr[2:0] == 3'd2 && $urandom_range(3) != 0) data = 16'($urandom_range(6));
        applyStimulus(iom, wen, addr, data, obs);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
